// File: rtl/line_transfer_engine.sv
// Cache line transfer engine: fills, writes and write-back-then-fills a cache line over a narrow RAM bus.
// Optional build macro LTE_CRITICAL_WORD_FIRST_EN starts reads at the beat holding the requested word.
module line_transfer_engine #(
  parameter int ADDR_SIZE = 16,
  parameter int BUS_SIZE  = 16,
  parameter int BEATS     = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      SIG_RD,
  input  logic                      SIG_WR,
  input  logic                      SIG_WB,
  input  logic [ADDR_SIZE-1:0]      IN_ADDR,
  input  logic [ADDR_SIZE-1:0]      IN_WB_ADDR,
  input  logic [BUS_SIZE*BEATS-1:0] IN_DATA,
  output logic [BUS_SIZE*BEATS-1:0] OUT_DATA,
  output logic                      ACK,
  output logic                      BUSY,
  output logic                      RAM_REQ,
  output logic                      RAM_READ_NOT_WRITE,
  output logic [ADDR_SIZE-1:0]      OUT_RAM_ADDR,
  output logic [BUS_SIZE-1:0]       OUT_RAM_DATA,
  input  logic [BUS_SIZE-1:0]       IN_RAM_DATA,
  input  logic                      RAM_ACK
);

  localparam int LINE_SIZE   = BUS_SIZE * BEATS;
  localparam int OFFSET_SIZE = $clog2(LINE_SIZE / 8);
  localparam int BYTE_BITS   = $clog2(BUS_SIZE / 8);
  localparam int BEAT_BITS   = OFFSET_SIZE - BYTE_BITS;
  localparam int LINE_ADDR_W = ADDR_SIZE - OFFSET_SIZE;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                          state;
  logic [BEAT_BITS-1:0]            beat;
  logic [BEAT_BITS-1:0]            count;
  logic [BEAT_BITS-1:0]            start_beat;
  logic [BEAT_BITS-1:0]            next_beat;
  logic [BEAT_BITS-1:0]            next_count;
  logic [BEAT_BITS-1:0]            crit_beat;
  logic [LINE_ADDR_W-1:0]          xfer_line;
  logic [LINE_ADDR_W-1:0]          fill_line;
  logic [LINE_ADDR_W-1:0]          req_line;
  logic                            wb_pending;
  logic [BEATS-1:0][BUS_SIZE-1:0]  line_buf;
  logic [BEATS-1:0][BUS_SIZE-1:0]  fill_buf;
  logic                            unused_bits;

  function automatic logic [ADDR_SIZE-1:0] beat_addr(input logic [LINE_ADDR_W-1:0] line,
                                                     input logic [BEAT_BITS-1:0]   b);
    return (ADDR_SIZE'(line) << OFFSET_SIZE) | (ADDR_SIZE'(b) << BYTE_BITS);
  endfunction

`ifdef LTE_CRITICAL_WORD_FIRST_EN
  assign crit_beat = IN_ADDR[OFFSET_SIZE-1:BYTE_BITS];
`else
  assign crit_beat = '0;
`endif

  // Offset bits only matter for critical-word selection; the rest address whole lines.
  assign unused_bits = ^{IN_ADDR[OFFSET_SIZE-1:0], IN_WB_ADDR[OFFSET_SIZE-1:0]};

  assign OUT_DATA = fill_buf;

  always_comb begin
    next_beat  = beat + BEAT_BITS'(1);
    next_count = count + BEAT_BITS'(1);
    req_line   = SIG_WB ? IN_WB_ADDR[ADDR_SIZE-1:OFFSET_SIZE] : IN_ADDR[ADDR_SIZE-1:OFFSET_SIZE];
  end

  // count tracks beats completed in the current phase, so a wrapped critical-word
  // read still ends after exactly BEATS beats whatever beat it started on.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state              <= IDLE;
      beat               <= '0;
      count              <= '0;
      start_beat         <= '0;
      xfer_line          <= '0;
      fill_line          <= '0;
      wb_pending         <= 1'b0;
      line_buf           <= '0;
      fill_buf           <= '0;
      ACK                <= 1'b0;
      BUSY               <= 1'b0;
      RAM_REQ            <= 1'b0;
      RAM_READ_NOT_WRITE <= 1'b1;
      OUT_RAM_ADDR       <= '0;
      OUT_RAM_DATA       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ACK <= 1'b0;
          if (SIG_WB || SIG_WR || SIG_RD) begin
            BUSY       <= 1'b1;
            RAM_REQ    <= 1'b1;
            count      <= '0;
            line_buf   <= IN_DATA;
            fill_line  <= IN_ADDR[ADDR_SIZE-1:OFFSET_SIZE];
            start_beat <= crit_beat;
            wb_pending <= SIG_WB;
            if (SIG_WB || SIG_WR) begin
              state              <= WRITE;
              beat               <= '0;
              xfer_line          <= req_line;
              RAM_READ_NOT_WRITE <= 1'b0;
              OUT_RAM_ADDR       <= beat_addr(req_line, '0);
              OUT_RAM_DATA       <= IN_DATA[BUS_SIZE-1:0];
            end else begin
              state              <= READ;
              beat               <= crit_beat;
              xfer_line          <= IN_ADDR[ADDR_SIZE-1:OFFSET_SIZE];
              RAM_READ_NOT_WRITE <= 1'b1;
              OUT_RAM_ADDR       <= beat_addr(IN_ADDR[ADDR_SIZE-1:OFFSET_SIZE], crit_beat);
            end
          end
        end

        WRITE: begin
          if (RAM_ACK) begin
            if (count == LAST_BEAT) begin
              if (wb_pending) begin
                state              <= READ;
                wb_pending         <= 1'b0;
                beat               <= start_beat;
                count              <= '0;
                xfer_line          <= fill_line;
                RAM_READ_NOT_WRITE <= 1'b1;
                OUT_RAM_ADDR       <= beat_addr(fill_line, start_beat);
              end else begin
                state   <= DONE;
                RAM_REQ <= 1'b0;
                ACK     <= 1'b1;
              end
            end else begin
              beat         <= next_beat;
              count        <= next_count;
              OUT_RAM_ADDR <= beat_addr(xfer_line, next_beat);
              OUT_RAM_DATA <= line_buf[next_beat];
            end
          end
        end

        READ: begin
          if (RAM_ACK) begin
            fill_buf[beat] <= IN_RAM_DATA;
            if (count == LAST_BEAT) begin
              state   <= DONE;
              RAM_REQ <= 1'b0;
              ACK     <= 1'b1;
            end else begin
              beat         <= next_beat;
              count        <= next_count;
              OUT_RAM_ADDR <= beat_addr(xfer_line, next_beat);
            end
          end
        end

        DONE: begin
          ACK   <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_transfer_engine.sv
// Directed self-checking bench for line_transfer_engine; the RAM returns the inverted beat address as read data.
// Critical-word expectations follow LTE_CRITICAL_WORD_FIRST_EN when it is defined.
module tb_line_transfer_engine;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         SIG_RD, SIG_WR, SIG_WB;
  logic [15:0]  IN_ADDR, IN_WB_ADDR;
  logic [127:0] IN_DATA;
  logic [127:0] OUT_DATA;
  logic         ACK, BUSY, RAM_REQ, RAM_READ_NOT_WRITE;
  logic [15:0]  OUT_RAM_ADDR;
  logic [15:0]  OUT_RAM_DATA;
  logic [15:0]  IN_RAM_DATA;
  logic         RAM_ACK;

  int checks   = 0;
  int failures = 0;

  line_transfer_engine dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .SIG_RD             (SIG_RD),
    .SIG_WR             (SIG_WR),
    .SIG_WB             (SIG_WB),
    .IN_ADDR            (IN_ADDR),
    .IN_WB_ADDR         (IN_WB_ADDR),
    .IN_DATA            (IN_DATA),
    .OUT_DATA           (OUT_DATA),
    .ACK                (ACK),
    .BUSY               (BUSY),
    .RAM_REQ            (RAM_REQ),
    .RAM_READ_NOT_WRITE (RAM_READ_NOT_WRITE),
    .OUT_RAM_ADDR       (OUT_RAM_ADDR),
    .OUT_RAM_DATA       (OUT_RAM_DATA),
    .IN_RAM_DATA        (IN_RAM_DATA),
    .RAM_ACK            (RAM_ACK)
  );

  always #5 CLK = ~CLK;

  assign IN_RAM_DATA = ~OUT_RAM_ADDR;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    RESET = 1'b1; SIG_WB = 1'b1; SIG_WR = 1'b1; SIG_RD = 1'b1; RAM_ACK = 1'b1;
    IN_ADDR = 16'h5555; IN_WB_ADDR = 16'hFFFF; IN_DATA = '1;
    next_cycle();
    next_cycle();
    got = {ACK, BUSY, RAM_REQ, RAM_READ_NOT_WRITE, OUT_RAM_ADDR, 1'b0};
    checks++;
    if (got !== {4'b0001, 16'h0000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%h exp=%h", got, {4'b0001, 16'h0000, 1'b0});
    end
    checks++;
    if (OUT_RAM_DATA !== 16'h0000 || OUT_DATA !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got ram_data=%h line=%h exp zeros", OUT_RAM_DATA, OUT_DATA);
    end
    RESET = 1'b0; SIG_WB = 1'b0; SIG_WR = 1'b0; SIG_RD = 1'b0;
    next_cycle();
    checks++;
    if ({BUSY, RAM_REQ} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_request_dropped got busy/req=%b exp=00", {BUSY, RAM_REQ});
    end
  endtask

  task automatic test_read();
    logic [19:0] got, exp;
    IN_ADDR = 16'h1234; SIG_RD = 1'b1;
    next_cycle();
    SIG_RD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got = {BUSY, ACK, RAM_REQ, RAM_READ_NOT_WRITE, OUT_RAM_ADDR};
      exp = {4'b1011, 16'h1230 + 16'(2 * k)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL read_beat%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
    checks++;
    if ({ACK, BUSY, RAM_REQ} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL read_done got ack/busy/req=%b exp=110", {ACK, BUSY, RAM_REQ});
    end
    checks++;
    if (OUT_DATA !== 128'hEDC1_EDC3_EDC5_EDC7_EDC9_EDCB_EDCD_EDCF) begin
      failures++;
      $display("[TB] FAIL read_line got=%h exp=%h", OUT_DATA, 128'hEDC1_EDC3_EDC5_EDC7_EDC9_EDCB_EDCD_EDCF);
    end
    next_cycle();
    checks++;
    if ({ACK, BUSY} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL read_idle got ack/busy=%b exp=00", {ACK, BUSY});
    end
  endtask

  task automatic test_critical_word();
    logic [19:0] got, exp;
    int first;
`ifdef LTE_CRITICAL_WORD_FIRST_EN
    first = 3;
`else
    first = 0;
`endif
    IN_ADDR = 16'h1236; SIG_RD = 1'b1;
    next_cycle();
    SIG_RD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got = {BUSY, ACK, RAM_REQ, RAM_READ_NOT_WRITE, OUT_RAM_ADDR};
      exp = {4'b1011, 16'h1230 + 16'(2 * ((k + first) % 8))};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL crit_beat%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
    checks++;
    if (ACK !== 1'b1 || OUT_DATA !== 128'hEDC1_EDC3_EDC5_EDC7_EDC9_EDCB_EDCD_EDCF) begin
      failures++;
      $display("[TB] FAIL crit_line got ack=%b line=%h exp ack=1 line=%h", ACK, OUT_DATA,
               128'hEDC1_EDC3_EDC5_EDC7_EDC9_EDCB_EDCD_EDCF);
    end
    next_cycle();
  endtask

  task automatic test_write_back();
    logic [35:0] got, exp;
    IN_WB_ADDR = 16'h0A00; IN_ADDR = 16'h0B00;
    IN_DATA = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    SIG_WB = 1'b1;
    next_cycle();
    SIG_WB = 1'b0;
    IN_DATA = '0;
    for (int k = 0; k < 16; k++) begin
      got = {BUSY, ACK, RAM_REQ, RAM_READ_NOT_WRITE, OUT_RAM_ADDR, (k < 8) ? OUT_RAM_DATA : 16'h0};
      if (k < 8) exp = {4'b1010, 16'h0A00 + 16'(2 * k), 16'(k)};
      else       exp = {4'b1011, 16'h0B00 + 16'(2 * (k - 8)), 16'h0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL wb_beat%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
    checks++;
    if ({ACK, BUSY, RAM_REQ} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL wb_done got ack/busy/req=%b exp=110", {ACK, BUSY, RAM_REQ});
    end
    checks++;
    if (OUT_DATA !== 128'hF4F1_F4F3_F4F5_F4F7_F4F9_F4FB_F4FD_F4FF) begin
      failures++;
      $display("[TB] FAIL wb_line got=%h exp=%h", OUT_DATA, 128'hF4F1_F4F3_F4F5_F4F7_F4F9_F4FB_F4FD_F4FF);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    logic [35:0] got, exp;
    int beat_at[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    IN_ADDR = 16'h2000;
    IN_DATA = 128'hC0D7_C0D6_C0D5_C0D4_C0D3_C0D2_C0D1_C0D0;
    SIG_RD = 1'b1; SIG_WR = 1'b1;
    next_cycle();
    SIG_RD = 1'b0; SIG_WR = 1'b0;
    for (int i = 0; i < 11; i++) begin
      RAM_ACK = (i < 2 || i > 4);
      got = {BUSY, ACK, RAM_REQ, RAM_READ_NOT_WRITE, OUT_RAM_ADDR, OUT_RAM_DATA};
      exp = {4'b1010, 16'h2000 + 16'(2 * beat_at[i]), 16'hC0D0 + 16'(beat_at[i])};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL stall_cycle%0d got=%h exp=%h", i + 1, got, exp);
      end
      next_cycle();
    end
    RAM_ACK = 1'b1;
    checks++;
    if ({ACK, RAM_REQ} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL stall_done got ack/req=%b exp=10", {ACK, RAM_REQ});
    end
    checks++;
    if (OUT_DATA !== 128'hF4F1_F4F3_F4F5_F4F7_F4F9_F4FB_F4FD_F4FF) begin
      failures++;
      $display("[TB] FAIL write_keeps_line got=%h exp=%h", OUT_DATA, 128'hF4F1_F4F3_F4F5_F4F7_F4F9_F4FB_F4FD_F4FF);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    int busy_cycles = 0;
    IN_ADDR = 16'h3000; SIG_RD = 1'b1;
    next_cycle();
    SIG_RD = 1'b0;
    for (int k = 0; k < 4; k++) next_cycle();
    checks++;
    if (OUT_RAM_ADDR !== 16'h3008) begin
      failures++;
      $display("[TB] FAIL abort_beat4_addr got=%h exp=3008", OUT_RAM_ADDR);
    end
    RESET = 1'b1; SIG_RD = 1'b1;
    next_cycle();
    RESET = 1'b0; SIG_RD = 1'b0;
    checks++;
    if ({ACK, BUSY, RAM_REQ, OUT_DATA} !== {3'b000, 128'h0}) begin
      failures++;
      $display("[TB] FAIL abort_state got ack/busy/req=%b line=%h exp 000 and zero line", {ACK, BUSY, RAM_REQ}, OUT_DATA);
    end
    for (int k = 0; k < 10; k++) begin
      if (ACK) acks++;
      if (BUSY) busy_cycles++;
      next_cycle();
    end
    checks++;
    if (acks !== 0 || busy_cycles !== 0) begin
      failures++;
      $display("[TB] FAIL abort_quiet got acks=%0d busy=%0d exp 0 and 0", acks, busy_cycles);
    end
    SIG_RD = 1'b1;
    next_cycle();
    SIG_RD = 1'b0;
    for (int k = 0; k < 8; k++) next_cycle();
    checks++;
    if (ACK !== 1'b1 || OUT_DATA !== 128'hCFF1_CFF3_CFF5_CFF7_CFF9_CFFB_CFFD_CFFF) begin
      failures++;
      $display("[TB] FAIL post_reset_read got ack=%b line=%h exp ack=1 line=%h", ACK, OUT_DATA,
               128'hCFF1_CFF3_CFF5_CFF7_CFF9_CFFB_CFFD_CFFF);
    end
    next_cycle();
  endtask

  task automatic test_ignore_busy();
    int acks = 0;
    int busy_late = 0;
    IN_ADDR = 16'h1234; SIG_RD = 1'b1;
    next_cycle();
    for (int c = 1; c <= 14; c++) begin
      SIG_RD = (c == 3 || c == 9);
      IN_ADDR = (c == 1) ? 16'h1234 : 16'h4000;
      if (ACK) acks++;
      if (c >= 10 && BUSY) busy_late++;
      next_cycle();
    end
    SIG_RD = 1'b0;
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("[TB] FAIL ignore_ack_count got=%0d exp=1", acks);
    end
    checks++;
    if (busy_late !== 0) begin
      failures++;
      $display("[TB] FAIL ignore_busy_after_done got=%0d busy cycles exp=0", busy_late);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] got;
    IN_ADDR = 16'h1234; SIG_RD = 1'b1;
    next_cycle();
    SIG_RD = 1'b0;
    for (int k = 0; k < 8; k++) next_cycle();
    checks++;
    if (ACK !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_first_ack got=%b exp=1", ACK);
    end
    next_cycle();
    IN_ADDR = 16'h5000; IN_DATA = 128'h0; SIG_WR = 1'b1;
    next_cycle();
    SIG_WR = 1'b0;
    got = {BUSY, ACK, RAM_REQ, RAM_READ_NOT_WRITE, OUT_RAM_ADDR};
    checks++;
    if (got !== {4'b1010, 16'h5000}) begin
      failures++;
      $display("[TB] FAIL b2b_accept got=%h exp=%h", got, {4'b1010, 16'h5000});
    end
    for (int k = 0; k < 8; k++) next_cycle();
    checks++;
    if ({ACK, BUSY} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL b2b_second_ack got ack/busy=%b exp=11", {ACK, BUSY});
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_read();
    test_critical_word();
    test_write_back();
    test_stall();
    test_reset_mid();
    test_ignore_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_transfer_engine.md
LINE_TRANSFER_ENGINE -- requirements
Module: line_transfer_engine

Interface
REQ-001 Parameter ADDR_SIZE, default 16, byte-address width of the cache and RAM side.
REQ-002 Parameter BUS_SIZE, default 16, RAM data bus width in bits; multiple of 8, power of two.
REQ-003 Parameter BEATS, default 8, bus beats per cache line; power of two, at least 2.
REQ-004 Derived: LINE_SIZE = BUS_SIZE*BEATS; OFFSET_SIZE = log2(LINE_SIZE/8); BYTE_BITS = log2(BUS_SIZE/8).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 CLK  input  1  sole clock; all state changes on rising edge.
REQ-007 RESET  input  1  synchronous, active-high reset.
REQ-008 SIG_RD  input  1  line-fill request.
REQ-009 SIG_WR  input  1  line-write request.
REQ-010 SIG_WB  input  1  write-back-then-fill request.
REQ-011 IN_ADDR  input  ADDR_SIZE  fill/write byte address; offset bits select the critical beat.
REQ-012 IN_WB_ADDR  input  ADDR_SIZE  victim line address for SIG_WB; offset bits ignored.
REQ-013 IN_DATA  input  LINE_SIZE  line to write; beat k = bits [k*BUS_SIZE +: BUS_SIZE].
REQ-014 OUT_DATA  output  LINE_SIZE  filled line, same beat packing.
REQ-015 ACK  output  1  one-cycle completion pulse.
REQ-016 BUSY  output  1  high from acceptance until the ACK cycle inclusive.
REQ-017 RAM_REQ  output  1  beat request to RAM.
REQ-018 RAM_READ_NOT_WRITE  output  1  1 = read beat, 0 = write beat.
REQ-019 OUT_RAM_ADDR  output  ADDR_SIZE  beat address = {line addr, beat index, BYTE_BITS zeros}.
REQ-020 OUT_RAM_DATA  output  BUS_SIZE  write beat data.
REQ-021 IN_RAM_DATA  input  BUS_SIZE  read beat data, valid with RAM_ACK.
REQ-022 RAM_ACK  input  1  completes the current beat in the cycle it is high while RAM_REQ is high.

Function
REQ-023 States SHALL be IDLE, WRITE, READ, DONE.
REQ-024 IDLE: a request sampled at an edge is accepted at that edge; priority SIG_WB > SIG_WR > SIG_RD; IN_ADDR, IN_WB_ADDR, IN_DATA latched at acceptance.
REQ-025 Requests while BUSY SHALL be ignored, not queued.
REQ-026 SIG_WR -> WRITE; SIG_RD -> READ; SIG_WB -> WRITE on IN_WB_ADDR, then READ on IN_ADDR without returning to IDLE.
REQ-027 RAM_REQ SHALL be high every cycle in WRITE/READ; address, data and RAM_READ_NOT_WRITE stable until RAM_ACK.
REQ-028 Beat advances on each RAM_ACK; with RAM_ACK held high one beat completes per cycle.
REQ-029 WRITE beats in order 0..BEATS-1; after beat BEATS-1 ack -> READ (SIG_WB) or DONE.
REQ-030 READ: IN_RAM_DATA stored into OUT_DATA slot of the beat index on RAM_ACK; after the last beat -> DONE.
REQ-031 DONE lasts exactly one cycle; ACK=1, BUSY=1, RAM_REQ=0; next state IDLE.
REQ-032 Beat counter SHALL be log2(BEATS) bits and wrap modulo BEATS.
REQ-033 A request high in the DONE cycle is ignored; a request high in the first IDLE cycle after DONE is accepted.
REQ-034 OUT_DATA holds its value until overwritten by the next read beat.

Reset
REQ-035 RESET high at an edge SHALL force IDLE regardless of state, abandoning any transfer.
REQ-036 Reset values: ACK=0, BUSY=0, RAM_REQ=0, RAM_READ_NOT_WRITE=1, OUT_RAM_ADDR=0, OUT_RAM_DATA=0, OUT_DATA=0, beat counter=0.
REQ-037 A request high during reset SHALL NOT be accepted.

Configuration
REQ-038 Macro LTE_CRITICAL_WORD_FIRST_EN defined: READ starts at beat IN_ADDR[OFFSET_SIZE-1:BYTE_BITS] and wraps modulo BEATS; OUT_DATA slot still equals beat index.
REQ-039 Macro undefined: READ always starts at beat 0; IN_ADDR offset bits ignored.

Verification (defaults; RAM_ACK held high unless stated)
REQ-040 SIG_RD, IN_ADDR=16'h1234, no macro -> RAM_REQ cycles 1..8, addresses 16'h1230,1232,...,123E, ACK in cycle 9, OUT_DATA = eight read beats in order.
REQ-041 Same with LTE_CRITICAL_WORD_FIRST_EN, IN_ADDR=16'h1236 -> address order 1236,1238,123A,123C,123E,1230,1232,1234; OUT_DATA identical to REQ-040 for same RAM contents.
REQ-042 SIG_WB, IN_WB_ADDR=16'h0A00, IN_ADDR=16'h0B00, IN_DATA=128'h0007..0000 -> 8 write beats 0A00..0A0E data 0000..0007, then 8 reads 0B00..0B0E, ACK in cycle 17.
REQ-043 SIG_RD and SIG_WR together -> write performed, RAM_READ_NOT_WRITE=0 on all 8 beats; RAM_ACK low 3 cycles on beat 2 -> address 0x..04 held 4 cycles, ACK delayed by 3.
REQ-044 RESET asserted during read beat 4 -> next cycle RAM_REQ=0, BUSY=0, ACK never pulses; new SIG_RD after reset completes normally.
REQ-045 SIG_RD pulsed while BUSY and in the DONE cycle -> ignored; exactly one ACK.
